// File: rtl/bus_bridge_io_pkg.sv
// Shared I/O address map, decode result type and the 7-segment glyph table.
// Latency: none (types and pure functions only); backpressure: n/a.
package bus_bridge_io_pkg;

    localparam logic [19:0] IO_PAGE    = 20'hFFFFF;
    localparam logic [11:0] ADDR_SEG   = 12'h000;
    localparam logic [11:0] ADDR_TIMER = 12'h020;
    localparam logic [11:0] ADDR_LED   = 12'h060;
    localparam logic [11:0] ADDR_SW    = 12'h070;
    localparam logic [11:0] ADDR_BTN   = 12'h078;

    typedef enum logic [2:0] {
        SEL_DRAM,
        SEL_SEG,
        SEL_TIMER,
        SEL_LED,
        SEL_SW,
        SEL_BTN,
        SEL_NONE
    } io_sel_e;

    function automatic io_sel_e addr_decode(input logic [31:0] addr);
        io_sel_e sel;
        if (addr[31:12] != IO_PAGE) begin
            sel = SEL_DRAM;
        end else begin
            case (addr[11:0])
                ADDR_SEG:   sel = SEL_SEG;
                ADDR_TIMER: sel = SEL_TIMER;
                ADDR_LED:   sel = SEL_LED;
                ADDR_SW:    sel = SEL_SW;
                ADDR_BTN:   sel = SEL_BTN;
                default:    sel = SEL_NONE;
            endcase
        end
        return sel;
    endfunction

    // Active-low {dp,g,f,e,d,c,b,a}; dp bit is always 1 (off).
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] cx;
        case (nib)
            4'h0: cx = 8'hC0;
            4'h1: cx = 8'hF9;
            4'h2: cx = 8'hA4;
            4'h3: cx = 8'hB0;
            4'h4: cx = 8'h99;
            4'h5: cx = 8'h92;
            4'h6: cx = 8'h82;
            4'h7: cx = 8'hF8;
            4'h8: cx = 8'h80;
            4'h9: cx = 8'h90;
            4'hA: cx = 8'h88;
            4'hB: cx = 8'h83;
            4'hC: cx = 8'hC6;
            4'hD: cx = 8'hA1;
            4'hE: cx = 8'h86;
            default: cx = 8'h8E;
        endcase
        return cx;
    endfunction

endpackage

// File: rtl/bus_bridge_io_seg7_scan.sv
// Multiplexed 8-digit 7-segment driver: scan counter, digit index and hex decode.
// Latency: a new value shows on the lit digit in the same cycle; backpressure: none.
module seg7_scan #(
    parameter int unsigned SCAN_DIV = 20000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] value,
    output logic [7:0]  an,
    output logic [7:0]  cx
);
    import bus_bridge_io_pkg::*;

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic          scan_wrap;

    always_comb begin
        scan_wrap  = (scan_cnt_q == CW'(SCAN_DIV - 1));
        scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + 1'b1;
        idx_d      = scan_wrap ? idx_q + 3'd1 : idx_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q <= '0;
            idx_q      <= '0;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
        end
    end

    // Segments decode straight from the live value so a write is seen without waiting for a scan step.
    always_comb begin
        an = ~(8'b1 << idx_q);
        cx = hex_to_seg(value[{idx_q, 2'b00} +: 4]);
    end

endmodule

// File: rtl/bus_bridge_io.sv
// MEM-stage bus bridge: address decode to DRAM or I/O registers, same-cycle read mux, timer, input syncs.
// Latency: reads combinational, writes visible after one edge; backpressure: none (bus never stalls).
module bus_bridge_io #(
    parameter int unsigned DRAM_AW  = 14,
    parameter int unsigned SCAN_DIV = 20000,
    parameter int unsigned TICK_DIV = 25
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        bus_addr,
    input  logic               bus_wen,
    input  logic [31:0]        bus_wdata,
    output logic [31:0]        bus_rdata,
    output logic [DRAM_AW-1:0] dram_addr,
    output logic               dram_wen,
    output logic [31:0]        dram_wdata,
    input  logic [31:0]        dram_rdata,
    input  logic [23:0]        sw_i,
    input  logic [4:0]         btn_i,
    output logic [23:0]        led_o,
    output logic [7:0]         seg_an_o,
    output logic [7:0]         seg_cx_o
);
    import bus_bridge_io_pkg::*;

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    io_sel_e       sel;
    logic          io_page;
    logic          tick;

    logic [23:0]   led_q, led_d;
    logic [31:0]   seg_val_q, seg_val_d;
    logic [31:0]   timer_q, timer_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [23:0]   sw_meta_q, sw_sync_q;
    logic [4:0]    btn_meta_q, btn_sync_q;

    always_comb begin
        sel        = addr_decode(bus_addr);
        io_page    = (bus_addr[31:12] == IO_PAGE);
        dram_addr  = bus_addr[DRAM_AW+1:2];
        dram_wen   = bus_wen & ~io_page;
        dram_wdata = bus_wdata;
    end

    always_comb begin
        led_d     = led_q;
        seg_val_d = seg_val_q;
        tick      = (presc_q == PW'(TICK_DIV - 1));
        presc_d   = tick ? '0 : presc_q + 1'b1;
        timer_d   = tick ? timer_q + 32'd1 : timer_q;
        if (bus_wen) begin
            case (sel)
                SEL_LED: led_d     = bus_wdata[23:0];
                SEL_SEG: seg_val_d = bus_wdata;
                // A CPU write overrides a tick landing on the same edge and restarts the prescale period.
                SEL_TIMER: begin
                    timer_d = bus_wdata;
                    presc_d = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q      <= '0;
            seg_val_q  <= '0;
            timer_q    <= '0;
            presc_q    <= '0;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            btn_meta_q <= '0;
            btn_sync_q <= '0;
        end else begin
            led_q      <= led_d;
            seg_val_q  <= seg_val_d;
            timer_q    <= timer_d;
            presc_q    <= presc_d;
            sw_meta_q  <= sw_i;
            sw_sync_q  <= sw_meta_q;
            btn_meta_q <= btn_i;
            btn_sync_q <= btn_meta_q;
        end
    end

    always_comb begin
        case (sel)
            SEL_DRAM:  bus_rdata = dram_rdata;
            SEL_SEG:   bus_rdata = seg_val_q;
            SEL_TIMER: bus_rdata = timer_q;
            SEL_LED:   bus_rdata = {8'h00, led_q};
            SEL_SW:    bus_rdata = {8'h00, sw_sync_q};
            SEL_BTN:   bus_rdata = {27'h0, btn_sync_q};
            default:   bus_rdata = 32'h0;
        endcase
    end

    assign led_o = led_q;

    seg7_scan #(
        .SCAN_DIV(SCAN_DIV)
    ) u_seg7_scan (
        .clk  (clk),
        .rst_n(rst_n),
        .value(seg_val_q),
        .an   (seg_an_o),
        .cx   (seg_cx_o)
    );

endmodule
